// File: rtl/pdm_mic_pkg.sv
// Shared definitions for the PDM microphone array front end:
// derived widths, FSM state encoding and the PDM bit-to-sample mapping.
package pdm_mic_pkg;

    // Integrator/comb width: 2-bit signed input grown by log2(R) per stage
    function automatic int acc_width(input int decim, input int order);
        return 2 + order * $clog2(decim);
    endfunction

    // Channel index width, kept at least one bit
    function automatic int ch_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMB    = 2'd1,
        ST_PRESENT = 2'd2
    } fsm_state_e;

    // PDM bit 1 -> +1, bit 0 -> -1
    localparam logic signed [1:0] PDM_ONE  = 2'sb01;
    localparam logic signed [1:0] PDM_ZERO = 2'sb11;

endpackage

// File: rtl/pdm_mic_array_if.sv
// PCM output stream: channel-serialised samples with valid/ready handshake.
interface pdm_mic_array_if #(
    parameter int OUT_W = 32,
    parameter int CH_W  = 3
);
    logic signed [OUT_W-1:0] out_tdata;
    logic [CH_W-1:0]         out_tchan;
    logic                    out_tlast;
    logic                    out_tvalid;
    logic                    out_tready;

    modport master (
        output out_tdata, out_tchan, out_tlast, out_tvalid,
        input  out_tready
    );

    modport slave (
        input  out_tdata, out_tchan, out_tlast, out_tvalid,
        output out_tready
    );
endinterface

// File: rtl/pdm_cic_integ.sv
// One channel's CIC integrator cascade. Each stage accumulates the previous
// stage's registered value on the channel's sample strobe; wraparound is
// intentional and cancelled by the comb section downstream.
module pdm_cic_integ #(
    parameter int ACC_W = 26,
    parameter int ORDER = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clr,
    input  logic                    i_stb,
    input  logic signed [1:0]       i_x,
    output logic signed [ACC_W-1:0] o_y
);
    logic signed [ACC_W-1:0] r_acc [ORDER];
    logic signed [ACC_W-1:0] w_x_ext;

    assign w_x_ext = {{(ACC_W-2){i_x[1]}}, i_x};
    assign o_y     = r_acc[ORDER-1];

    // Integrator cascade: clear on disable, accumulate on strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < ORDER; s++) r_acc[s] <= '0;
        end else if (i_clr) begin
            for (int s = 0; s < ORDER; s++) r_acc[s] <= '0;
        end else if (i_stb) begin
            r_acc[0] <= r_acc[0] + w_x_ext;
            for (int s = 1; s < ORDER; s++) r_acc[s] <= r_acc[s] + r_acc[s-1];
        end
    end
endmodule

// File: rtl/pdm_mic_array.sv
// Multi-line stereo PDM microphone front end: mic clock generation,
// dual-edge capture, per-channel CIC decimation and a channel-serialised
// PCM output stream with overrun detection.
module pdm_mic_array
    import pdm_mic_pkg::*;
#(
    parameter int N_LINES   = 4,
    parameter int CLK_DIV   = 25,
    parameter int DECIM     = 64,
    parameter int CIC_ORDER = 4,
    parameter int OUT_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr_ovr,
    output logic               m_clk,
    input  logic [N_LINES-1:0] m_data,
    pdm_mic_array_if.master    pcm,
    output logic               overrun
);
    localparam int NCH    = 2 * N_LINES;
    localparam int ACC_W  = acc_width(DECIM, CIC_ORDER);
    localparam int CH_W   = ch_width(NCH);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    if (CLK_DIV < 4) begin : g_chk_div
        $error("pdm_mic_array: CLK_DIV must be >= 4");
    end
    if (OUT_W < ACC_W) begin : g_chk_outw
        $error("pdm_mic_array: OUT_W must be >= ACC_W");
    end

    // Clock generator
    logic [DIV_W-1:0] r_div;
    logic             r_mclk;
    logic             w_div_tc;
    logic             w_stb_hi;
    logic             w_stb_lo;

    // Capture and integrators
    logic [N_LINES-1:0]      r_sync1;
    logic [N_LINES-1:0]      r_sync2;
    logic signed [1:0]       w_pdm_x [NCH];
    logic [NCH-1:0]          w_ch_stb;
    logic signed [ACC_W-1:0] w_integ [NCH];

    // Decimation
    logic [DCNT_W-1:0] r_dcnt;
    logic              w_frame_end;
    logic              r_snap_req;

    // Comb datapath and output FSM
    fsm_state_e              r_state;
    logic [CH_W-1:0]         r_ch;
    logic signed [ACC_W-1:0] r_snap [NCH];
    logic signed [ACC_W-1:0] r_dly  [NCH][CIC_ORDER];
    logic signed [ACC_W-1:0] w_stage [CIC_ORDER+1];
    logic signed [OUT_W-1:0] r_tdata;
    logic [CH_W-1:0]         r_tchan;
    logic                    r_tlast;
    logic                    r_tvalid;
    logic                    r_overrun;
    logic                    w_ovr_set;

    assign w_div_tc = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_stb_hi = en &&  r_mclk && w_div_tc;
    assign w_stb_lo = en && !r_mclk && w_div_tc;

    // Mic clock divider; when disabled, finish a high half-period then park low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_mclk <= 1'b0;
        end else if (en || r_mclk) begin
            if (w_div_tc) begin
                r_div  <= '0;
                r_mclk <= ~r_mclk;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end else begin
            r_div <= '0;
        end
    end

    // Two-flop synchroniser for the asynchronous PDM pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= m_data;
            r_sync2 <= r_sync1;
        end
    end

    // Even channels sample at the end of the high half, odd at the end of the low half
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign w_pdm_x[c]  = r_sync2[c/2] ? PDM_ONE : PDM_ZERO;
        assign w_ch_stb[c] = ((c % 2) == 0) ? w_stb_hi : w_stb_lo;

        pdm_cic_integ #(
            .ACC_W (ACC_W),
            .ORDER (CIC_ORDER)
        ) u_integ (
            .clk   (clk),
            .rst_n (rst_n),
            .i_clr (!en),
            .i_stb (w_ch_stb[c]),
            .i_x   (w_pdm_x[c]),
            .o_y   (w_integ[c])
        );
    end

    assign w_frame_end = w_stb_lo && (r_dcnt == DCNT_W'(DECIM - 1));

    // Decimation counter over m_clk periods; the snapshot request lags one
    // cycle so the falling-slot integrator update has landed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dcnt     <= '0;
            r_snap_req <= 1'b0;
        end else if (!en) begin
            r_dcnt     <= '0;
            r_snap_req <= 1'b0;
        end else begin
            r_snap_req <= w_frame_end;
            if (w_stb_lo) begin
                r_dcnt <= w_frame_end ? '0 : r_dcnt + DCNT_W'(1);
            end
        end
    end

    // Comb cascade for the channel currently being processed
    always_comb begin
        w_stage[0] = r_snap[r_ch];
        for (int s = 0; s < CIC_ORDER; s++) begin
            w_stage[s+1] = w_stage[s] - r_dly[r_ch][s];
        end
    end

    // Output FSM: snapshot in IDLE, one comb step per channel, hold until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ch     <= '0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tchan  <= '0;
            r_tlast  <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                r_snap[c] <= '0;
                for (int s = 0; s < CIC_ORDER; s++) r_dly[c][s] <= '0;
            end
        end else if (!en) begin
            r_state  <= ST_IDLE;
            r_ch     <= '0;
            r_tvalid <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                r_snap[c] <= '0;
                for (int s = 0; s < CIC_ORDER; s++) r_dly[c][s] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_snap_req) begin
                        r_snap  <= w_integ;
                        r_ch    <= '0;
                        r_state <= ST_COMB;
                    end
                end
                ST_COMB: begin
                    for (int s = 0; s < CIC_ORDER; s++) r_dly[r_ch][s] <= w_stage[s];
                    r_tdata  <= OUT_W'(w_stage[CIC_ORDER]);
                    r_tchan  <= r_ch;
                    r_tlast  <= (r_ch == CH_W'(NCH - 1));
                    r_tvalid <= 1'b1;
                    r_state  <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (pcm.out_tready) begin
                        r_tvalid <= 1'b0;
                        if (r_tlast) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_ch    <= r_ch + CH_W'(1);
                            r_state <= ST_COMB;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A snapshot that finds the FSM busy is dropped; the next comb output of
    // each channel then spans two decimation periods
    assign w_ovr_set = r_snap_req && (r_state != ST_IDLE);

    // Sticky overrun flag; a new overrun wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end else if (clr_ovr) begin
            r_overrun <= 1'b0;
        end
    end

    assign m_clk          = r_mclk;
    assign pcm.out_tdata  = r_tdata;
    assign pcm.out_tchan  = r_tchan;
    assign pcm.out_tlast  = r_tlast;
    assign pcm.out_tvalid = r_tvalid;
    assign overrun        = r_overrun;
endmodule
